// File: rtl/ascii_pair_serializer.sv
// Serializes a two-character ASCII word into a byte stream, optionally dropping a leading '0'/' '.
// Define ASCII_PAIR_SERIALIZER_NEWLINE_EN to append 8'h0A after every pair.
module ascii_pair_serializer #(
  parameter bit SKIP_LEAD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [15:0] in_,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [7:0]  out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
`ifdef ASCII_PAIR_SERIALIZER_NEWLINE_EN
    SEND_LO = 2'd2,
    SEND_NL = 2'd3
`else
    SEND_LO = 2'd2
`endif
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hi;
  logic [7:0] lo;
  logic       accept;
  logic       lead_skip;

  assign in_rdy    = (state == IDLE) && reset;
  assign accept    = in_val && in_rdy;
  assign lead_skip = SKIP_LEAD && ((in_[15:8] == 8'h30) || (in_[15:8] == 8'h20));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      hi    <= 8'h00;
      lo    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hi <= in_[15:8];
        lo <= in_[7:0];
      end
    end
  end

  // Outputs decode from state and registered bytes only, so out/out_val never see in_* or out_rdy.
  always_comb begin
    state_nxt = state;
    out_val   = 1'b0;
    out       = 8'h00;
    case (state)
      IDLE: begin
        if (accept) state_nxt = lead_skip ? SEND_LO : SEND_HI;
      end
      SEND_HI: begin
        out_val = 1'b1;
        out     = hi;
        if (out_rdy) state_nxt = SEND_LO;
      end
      SEND_LO: begin
        out_val = 1'b1;
        out     = lo;
`ifdef ASCII_PAIR_SERIALIZER_NEWLINE_EN
        if (out_rdy) state_nxt = SEND_NL;
`else
        if (out_rdy) state_nxt = IDLE;
`endif
      end
`ifdef ASCII_PAIR_SERIALIZER_NEWLINE_EN
      SEND_NL: begin
        out_val = 1'b1;
        out     = 8'h0A;
        if (out_rdy) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/ascii_pair_serializer.md
Name: ascii_pair_serializer

Overview:
- Downstream stage of the 4-bit binary-to-ASCII converter.
- Accepts one 16-bit two-character ASCII word per transaction on a val/rdy input. Upper byte is the first character, lower byte the second.
- Emits the characters one byte at a time on a val/rdy output that feeds the console/UART byte stream.
- Optionally drops a leading '0' or ' ' character.

Parameters:
- SKIP_LEAD, 1: when 1, the first byte is not emitted if it equals 8'h30 ('0') or 8'h20 (' '). When 0, both bytes are always emitted.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-low; asserted when reset==0 at a rising edge of clk.
- in_val, input, 1: upstream word valid.
- in_rdy, output, 1: block can accept a word.
- in_, input, 16: [15:8] first ASCII char, [7:0] second ASCII char.
- out_val, output, 1: out holds a valid byte.
- out_rdy, input, 1: downstream accepts byte.
- out, output, 8: ASCII byte.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, data regs cleared to 0.
  - Reset outputs: out_val=0, out=8'h00, busy=0.
  - in_rdy=0 while reset is low; in_rdy=1 in the first cycle after release.
- Reset mid-transfer aborts any pending bytes; no partial byte is emitted afterwards.
- States: IDLE, SEND_HI, SEND_LO (plus SEND_NL with the optional feature).
- in_rdy = (state==IDLE) && reset; combinational from state only.
  - No bypass: the output is never valid in the accept cycle.
- Accept: on in_val && in_rdy, register in_.
  - If SKIP_LEAD && in_[15:8] in {8'h30, 8'h20}, next state is SEND_LO; otherwise SEND_HI.
- SEND_HI: out_val=1, out=hi byte. On out_rdy, go to SEND_LO.
- SEND_LO: out_val=1, out=lo byte. On out_rdy, go to IDLE (or SEND_NL if the feature is enabled).
- out and out_val are registered/state-decoded, with no combinational path from in_* or out_rdy.
- Backpressure: while out_val=1 && out_rdy=0, out holds stable and the state does not advance.
- Latency: word accepted at edge N; first byte valid in cycle N+1.
- Throughput with out_rdy held high:
  - 3 cycles per word (accept, HI, LO).
  - 2 cycles per word when the lead byte is skipped.
- No checking of ASCII legality. Any byte values pass through unchanged except for the skip test.
- in_val while busy is ignored (in_rdy=0); the upstream must hold the word.
- The lo byte is never skipped, even if it is '0' or ' '.

Optional Feature:
- Macro: ASCII_PAIR_SERIALIZER_NEWLINE_EN.
- Defined: after SEND_LO handshakes, enter SEND_NL with out=8'h0A, out_val=1; on out_rdy, go to IDLE. busy stays high through SEND_NL. Unskipped throughput becomes 4 cycles per word.
- Undefined: SEND_NL does not exist; SEND_LO returns directly to IDLE.

Test Plan:
- Reset, then in_=16'h3135 ("15"), out_rdy=1: out 8'h31 in cycle N+1, 8'h35 in cycle N+2; in_rdy back to 1 in cycle N+3; busy=1 only in N+1..N+2.
- SKIP_LEAD=1, in_=16'h3037 ("07"): only 8'h37 emitted in cycle N+1. With an instance where SKIP_LEAD=0: 8'h30 then 8'h37.
- in_=16'h2039 (" 9") with SKIP_LEAD=1: only 8'h39. in_=16'h3130: 8'h31 then 8'h30 (lo '0' kept).
- Backpressure: in_=16'h3132, out_rdy=0 for 3 cycles. out stays 8'h31 with out_val=1 and in_rdy=0; after out_rdy=1, 8'h32 follows.
- Reset mid-operation: accept 16'h3134, pull reset=0 during SEND_HI. Next cycle out_val=0, busy=0; after release in_rdy=1 and no 8'h34 is ever emitted.
- Back-to-back: in_val held high with 16'h3130, 16'h3131, 16'h3132, out_rdy=1. Byte stream is 31 30 31 31 31 32, with one accept gap per word. With NEWLINE_EN, 8'h0A follows each pair.
